// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit with HI/LO result registers.
// Fixed latency: shift-add multiply or restoring divide over WIDTH iterations.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             ReadHi,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIXUP} state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               divzero_q, divzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes; -2^(W-1) maps to unsigned 2^(W-1)
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = a_q[WIDTH-1] ? (WIDTH'(0) - a_q) : a_q;
  assign mag_b = b_q[WIDTH-1] ? (WIDTH'(0) - b_q) : b_q;

  // One multiply step: add multiplicand when multiplier LSB set, then shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, dvs_q} : '0);

  // One restoring divide step on the partial remainder
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  assign rem_sh   = {acc_q, work_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, dvs_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - dvs_q;

  logic [PW-1:0] prod, prod_fix;
  logic          sgn_a, sgn_b;
  assign sgn_a    = a_q[WIDTH-1];
  assign sgn_b    = b_q[WIDTH-1];
  assign prod     = {acc_q, work_q};
  assign prod_fix = (sgn_a ^ sgn_b) ? (PW'(0) - prod) : prod;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_PREP;
      S_PREP:  state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dvs_d     = dvs_q;
    acc_d     = acc_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    divzero_d = divzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d = Op;
          a_d  = OpA;
          b_d  = OpB;
        end
      end
      S_PREP: begin
        acc_d     = '0;
        cnt_d     = '0;
        divzero_d = op_q & (b_q == '0);
        if (op_q) begin
          work_d = mag_a;
          dvs_d  = mag_b;
        end else begin
          work_d = mag_b;
          dvs_d  = mag_a;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_q) begin
          {acc_d, work_d} = {mul_sum, work_q[WIDTH-1:1]};
        end else begin
          acc_d  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
          work_d = {work_q[WIDTH-2:0], rem_ge};
        end
      end
      S_FIXUP: begin
        done_d = 1'b1;
        if (!op_q) begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (divzero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = (sgn_a ^ sgn_b) ? (WIDTH'(0) - work_q) : work_q;
          hi_d = sgn_a ? (WIDTH'(0) - acc_q) : acc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      acc_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dvs_q     <= dvs_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Stall must react to decode inputs in the same cycle
  always_comb begin
    Busy  = (state_q != S_IDLE);
    Stall = Busy & (ReadHi | Start);
    Done  = done_q;
    Hi    = hi_q;
    Lo    = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO and Done cycle queued at issue.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic          Op;
  logic [W-1:0]  OpA;
  logic [W-1:0]  OpB;
  logic          ReadHi;
  logic          Busy;
  logic          Done;
  logic          Stall;
  logic [W-1:0]  Hi;
  logic [W-1:0]  Lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (reset),
    .Start (Start),
    .Op    (Op),
    .OpA   (OpA),
    .OpB   (OpB),
    .ReadHi(ReadHi),
    .Busy  (Busy),
    .Done  (Done),
    .Stall (Stall),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference result using native signed arithmetic
  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned due);
    exp_t   e;
    longint p;
    int     sa;
    int     sbv;
    e.due = due;
    if (!op) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.lo = '1;
      e.hi = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = '0;
    end else begin
      sa   = $signed(a);
      sbv  = $signed(b);
      e.lo = 32'(sa / sbv);
      e.hi = 32'(sa % sbv);
    end
    return e;
  endfunction

  // Result monitor: pop and compare on every Done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset && Done) begin
      if (sb_q.size() == 0) begin
        check_val("done_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check_val("hi", Hi, e.hi);
        check_val("lo", Lo, e.lo);
        check_val("done_cycle", cyc, e.due);
        check_val("idle_on_done", Busy, 1'b0);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  // Called at a negedge with the DUT idle
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    sb_q.push_back(model(op, a, b, cyc + 35));
    Start = 1'b1;
    Op    = op;
    OpA   = a;
    OpB   = b;
    @(negedge clk);
    Start = 1'b0;
    check_val("busy_after_start", Busy, 1'b1);
    check_val("hi_hold", Hi, last_hi);
    check_val("lo_hold", Lo, last_lo);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  int unsigned due1;

  initial begin
    reset  = 1'b1;
    Start  = 1'b0;
    Op     = 1'b0;
    OpA    = '0;
    OpB    = '0;
    ReadHi = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", Busy, 1'b0);
    check_val("rst_done", Done, 1'b0);
    check_val("rst_hi", Hi, '0);
    check_val("rst_lo", Lo, '0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd7, 32'hFFFF_FFFD);          drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);          drain();
    issue(1'b1, 32'd5, 32'd0);                  drain();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);  drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'd0);          drain();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      issue(1'(i % 2), ra, rb);
      drain();
    end

    // ReadHi while idle never stalls
    @(negedge clk);
    ReadHi = 1'b1;
    #1 check_val("idle_readhi_stall", Stall, 1'b0);
    ReadHi = 1'b0;

    // Hazards: hold ReadHi and Start from cycle 2 of a multiply
    @(negedge clk);
    due1 = cyc + 35;
    issue(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
    @(negedge clk);
    ReadHi = 1'b1;
    Start  = 1'b1;
    Op     = 1'b1;
    OpA    = 32'd1000;
    OpB    = 32'hFFFF_FFF9;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check_val("hazard_stall", Stall, (cyc < due1) ? 1'b1 : 1'b0);
      if (cyc >= due1) begin
        check_val("hazard_done", Done, 1'b1);
        sb_q.push_back(model(1'b1, 32'd1000, 32'hFFFF_FFF9, cyc + 35));
        break;
      end
    end
    @(negedge clk);
    Start  = 1'b0;
    ReadHi = 1'b0;
    check_val("b2b_busy", Busy, 1'b1);
    drain();

    // Reset in the middle of RUN aborts and clears results
    @(negedge clk);
    issue(1'b0, 32'hDEAD_BEEF, 32'd77);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_val("midrst_busy", Busy, 1'b0);
    check_val("midrst_done", Done, 1'b0);
    check_val("midrst_hi", Hi, '0);
    check_val("midrst_lo", Lo, '0);
    reset   = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    issue(1'b0, 32'd3, 32'd4);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
